// File: rtl/spi_slave_fsm_pkg.sv
// Shared types for the SPI slave control FSM: state encoding, R/W bit
// definition, control-output bundle and small decode helpers.
package spi_slave_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    GET_ADDR     = 3'd1,
    GOT_ADDR     = 3'd2,
    READ_LOAD    = 3'd3,
    READ_SHIFT   = 3'd4,
    WRITE_RECV   = 3'd5,
    WRITE_COMMIT = 3'd6,
    DONE         = 3'd7
  } spiState_t;

  // Last bit of the address phase selects the transfer direction.
  localparam int RW_BIT = 0;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } rwBit_t;

  typedef struct packed {
    logic addrWe;
    logic dmWe;
    logic srWe;
    logic misoBuffEn;
  } spiCtrl_t;

  function automatic int countWidth(input int addrBits, input int dataBits);
    int maxCount;
    maxCount = (addrBits + 1 > dataBits) ? addrBits + 1 : dataBits;
    return $clog2(maxCount + 1);
  endfunction

  function automatic logic isCountingState(input spiState_t s);
    return s inside {GET_ADDR, READ_SHIFT, WRITE_RECV};
  endfunction

  function automatic spiCtrl_t decodeCtrl(input spiState_t s);
    spiCtrl_t c;
    c = '0;
    case (s)
      GOT_ADDR:     c.addrWe     = 1'b1;
      READ_LOAD:    c.srWe       = 1'b1;
      READ_SHIFT:   c.misoBuffEn = 1'b1;
      WRITE_COMMIT: c.dmWe       = 1'b1;
      default:      ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Saturating SCLK-edge counter with synchronous clear; 'hit' flags the
// enabled pulse that brings the count up to the terminal value.
module spi_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic             hit
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count;
  logic             atMax;

  assign atMax = (count == '1);
  assign hit   = enable && !atMax && ((count + ONE) == terminal);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !atMax) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI memory-slave control FSM with registered Moore outputs.
// Optional sticky abort indicator: define SPI_SLAVE_FSM_ABORT_FLAG_EN.
module spi_slave_fsm
  import spi_slave_fsm_pkg::*;
#(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs_conditioned,
  input  logic                 sclk_posedge,
  input  logic [DATA_BITS-1:0] shift_parallel,
  output logic                 addr_we,
  output logic                 dm_we,
  output logic                 sr_we,
  output logic                 miso_buff_en
`ifdef SPI_SLAVE_FSM_ABORT_FLAG_EN
  ,
  output logic                 aborted
`endif
);

  localparam int CNT_W = countWidth(ADDR_BITS, DATA_BITS);

  spiState_t        state;
  spiState_t        nextState;
  spiCtrl_t         ctrl;
  logic             countClear;
  logic             countEnable;
  logic             countHit;
  logic [CNT_W-1:0] countTerminal;

  // The address bits are consumed by the external address latch, not here.
  logic unusedAddrBits;
  assign unusedAddrBits = ^shift_parallel[DATA_BITS-1:RW_BIT+1];

  assign countEnable   = sclk_posedge && isCountingState(state);
  assign countTerminal = (state == GET_ADDR) ? CNT_W'(ADDR_BITS + 1) : CNT_W'(DATA_BITS);
  assign countClear    = cs_conditioned || !isCountingState(state) || countHit;

  spi_bit_counter #(
    .WIDTH(CNT_W)
  ) u_bitCounter (
    .clk     (clk),
    .reset   (reset),
    .clear   (countClear),
    .enable  (countEnable),
    .terminal(countTerminal),
    .hit     (countHit)
  );

  // NOTE: nextState gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    if (cs_conditioned) begin
      // Chip-select release wins over every other transition, even a
      // count completing on the same edge.
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:         nextState = GET_ADDR;
        GET_ADDR:     if (countHit) nextState = GOT_ADDR;
        GOT_ADDR:     nextState = (rwBit_t'(shift_parallel[RW_BIT]) == READ) ? READ_LOAD
                                                                               : WRITE_RECV;
        READ_LOAD:    nextState = READ_SHIFT;
        READ_SHIFT:   if (countHit) nextState = DONE;
        WRITE_RECV:   if (countHit) nextState = WRITE_COMMIT;
        WRITE_COMMIT: nextState = DONE;
        DONE:         nextState = DONE;
        default:      nextState = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered with it, so they
  // are glitch-free and drop asynchronously with reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ctrl  <= '0;
    end else begin
      state <= nextState;
      ctrl  <= decodeCtrl(nextState);
    end
  end

  assign addr_we      = ctrl.addrWe;
  assign dm_we        = ctrl.dmWe;
  assign sr_we        = ctrl.srWe;
  assign miso_buff_en = ctrl.misoBuffEn;

`ifdef SPI_SLAVE_FSM_ABORT_FLAG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aborted <= 1'b0;
    end else if (state == IDLE && !cs_conditioned) begin
      aborted <= 1'b0;
    end else if (cs_conditioned && !(state inside {IDLE, WRITE_COMMIT, DONE})) begin
      aborted <= 1'b1;
    end
  end
`endif

endmodule
